io_seg_scan: RTL and testbench
==============================

// Module: io_seg_scan
// PURPOSE
//  Parametrised multiplexed 7-segment driver: time-multiplexes DIGITS hex digits onto one shared segment bus.
//  It generates its own scan timing, 16-level PWM brightness, per-digit blank/blink/decimal-point control,
//  and tear-free frame-synchronous updates.
//  Sits between the CPU-facing display register block and the board anode/segment pins.
// PARAMETERS
//  DIGITS       8      number of digits (2..16)
//  SUB          3125   clocks per brightness sub-phase; one digit slot = 16*SUB clocks
//  BLINK_FRAMES 64     frames per blink half-period
//  ACTIVE_LOW   1      1: an/seg driven active-low at the pins; 0: active-high
// PORTS
//  clk        in   1          system clock
//  rst        in   1          synchronous, active-high reset
//  load       in   1          1-cycle strobe: capture data/dp/blank/blink/bright into the pending registers
//  data       in   4*DIGITS   hex nibble per digit; digit i = data[4i+3:4i]
//  dp         in   DIGITS     decimal point on, per digit
//  blank      in   DIGITS     force digit dark
//  blink      in   DIGITS     digit blinks with the blink phase
//  bright     in   4          on-time = (bright+1)/16 of each slot
//  an         out  DIGITS     anode enables, one-hot-or-none (pin polarity set by ACTIVE_LOW)
//  seg        out  8          {dp,g,f,e,d,c,b,a} (pin polarity set by ACTIVE_LOW)
//  frame_done out  1          1-cycle pulse as the last digit slot ends
// BEHAVIOUR
//  - Reset: an and seg all inactive (all 1 when ACTIVE_LOW); frame_done=0.
//    Counters, digit index and blink phase = 0.
//    Pending and active registers: data=0, dp=0, blink=0, bright=0, blank=all ones, so the display is dark.
//  - Timing: sub_cnt runs 0..SUB-1. phase (4b) increments when sub_cnt wraps.
//    When phase wraps 15->0 the digit slot ends and idx increments.
//    idx wraps DIGITS-1 -> 0; that wrap cycle is the frame end.
//  - frame_done = 1 for exactly the frame-end cycle.
//  - Double buffering:
//    - load writes the pending registers; multiple loads in one frame: the last one wins.
//    - Pending is copied to active on the frame-end cycle only.
//    - If load coincides with frame end, the incoming port values go straight to active (bypass).
//    - A load mid-frame never changes the frame currently displayed.
//  - Blink: frame counter 0..BLINK_FRAMES-1; blink_ph toggles at its wrap.
//  - Digit i is dark if any of the following holds:
//    - active blank[i] is set;
//    - active blink[i] is set and blink_ph is 1;
//    - phase > active bright.
//  - Output, registered, 1-cycle latency after counter state:
//    - lit digit: an = onehot(idx), seg = {dp[idx], decode(data[idx])};
//    - dark digit: an and seg are all inactive.
//    - Pin level = internal ^ {ACTIVE_LOW}.
//  - Decode 0-F (gfedcba): 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
//  - At most one anode active in any cycle.
//  - At every slot change (phase 15->0) the output is dark for one cycle (ghosting guard).
//  - Reset mid-frame: everything returns to the reset state on the next edge. No partial frame output.
//  - Widths: idx is $clog2(DIGITS); sub_cnt is $clog2(SUB); blink counter is $clog2(BLINK_FRAMES).
// STRUCTURE
//  - Package io_seg_pkg holds:
//    - the SEG_HEX[16] 7-bit decode table;
//    - localparam SEG_OFF = 8'h00 (internal polarity);
//    - function seg_decode(nibble).
//  - Sub-module io_seg_timebase: sub_cnt/phase/idx/blink counters, frame_end and blink_ph outputs.
//  - Top level: shadow/active registers, dark logic, output registers.
// TESTING  (DIGITS=4, SUB=2, BLINK_FRAMES=2, ACTIVE_LOW=1; slot=32 clk, frame=128 clk)
//  1. Reset, no load -> an=4'hF and seg=8'hFF for 300 cycles; frame_done pulses every 128 cycles.
//  2. load data=16'h3210, blank=0, bright=15 mid-frame -> old dark frame is completed first.
//     Next frame: an=1110 seg=~8'h3F, then 1101/~06, 1011/~5B, 0111/~4F, 31 cycles each + 1 dark.
//  3. bright=3, digit 0 -> an active for 8 cycles (phases 0..3) of each 32-cycle slot, then dark.
//  4. blink=4'b0010, dp=4'b0001 -> digit1 lit in frames with blink_ph=0, dark in the next 2 frames.
//     Digit0 seg bit7 is low (dp on).
//  5. Two loads in one frame (16'h1111 then 16'hABCD) -> next frame shows ABCD.
//     A load on the frame-end cycle is displayed in the frame starting next cycle.
//  6. rst asserted mid-slot -> an/seg go inactive the next cycle and the frame_done period restarts from 0.
//     Assertion throughout: $onehot0(~an).

Source files
------------

// File: rtl/io_seg_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: hex glyph table and segment-off pattern.
package io_seg_pkg;

    // gfedcba glyphs for 0-F, internal (active-high) polarity
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [7:0] SEG_OFF = 8'h00;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

endpackage

// File: rtl/io_seg_timebase.sv
// Scan timebase: sub-phase / PWM phase / digit index / blink frame counters.
// Latency: counters advance every clock; slot_end and frame_end decode the current state. No backpressure.
// Backpressure: none, free-running from reset.
module io_seg_timebase #(
    parameter int DIGITS       = 8,
    parameter int SUB          = 3125,
    parameter int BLINK_FRAMES = 64,
    parameter int IW           = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic [IW-1:0] idx,
    output logic [3:0]    phase,
    output logic          slot_end,
    output logic          frame_end,
    output logic          blink_ph
);
    localparam int SW = (SUB > 1) ? $clog2(SUB) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SW-1:0] SUB_LAST   = SW'(SUB - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [SW-1:0] sub_cnt;
    logic [BW-1:0] blink_cnt;
    logic          sub_wrap;

    assign sub_wrap  = (sub_cnt == SUB_LAST);
    assign slot_end  = sub_wrap && (phase == 4'hF);
    assign frame_end = slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_cnt   <= '0;
            phase     <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
            if (sub_wrap) begin
                phase <= phase + 4'd1;
            end
            if (slot_end) begin
                idx <= frame_end ? '0 : idx + 1'b1;
            end
            if (frame_end) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/io_seg_scan.sv
// Multiplexed 7-segment driver with PWM brightness, blink/blank/dp control and frame-synchronous updates.
// Latency: an/seg registered one clock after the timebase state; frame_done coincides with the frame-end cycle.
// Backpressure: none; load is always accepted into the pending bank, last load in a frame wins.
module io_seg_scan
    import io_seg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int SUB          = 3125,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     blink,
    input  logic [3:0]            bright,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_done
);
    localparam int   IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [IW-1:0]       idx;
    logic [3:0]          phase;
    logic                slot_end;
    logic                frame_end;
    logic                blink_ph;

    logic [4*DIGITS-1:0] p_data, a_data;
    logic [DIGITS-1:0]   p_dp, a_dp;
    logic [DIGITS-1:0]   p_blank, a_blank;
    logic [DIGITS-1:0]   p_blink, a_blink;
    logic [3:0]          p_bright, a_bright;

    logic                dark;
    logic [3:0]          nib;
    logic [DIGITS-1:0]   an_int;
    logic [7:0]          seg_int;

    io_seg_timebase #(
        .DIGITS       (DIGITS),
        .SUB          (SUB),
        .BLINK_FRAMES (BLINK_FRAMES),
        .IW           (IW)
    ) u_timebase (
        .clk       (clk),
        .rst       (rst),
        .idx       (idx),
        .phase     (phase),
        .slot_end  (slot_end),
        .frame_end (frame_end),
        .blink_ph  (blink_ph)
    );

    // Pending bank takes every load; active bank only changes at the frame boundary,
    // with a load on that exact cycle going straight through.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_data   <= '0;
            p_dp     <= '0;
            p_blank  <= '1;
            p_blink  <= '0;
            p_bright <= '0;
            a_data   <= '0;
            a_dp     <= '0;
            a_blank  <= '1;
            a_blink  <= '0;
            a_bright <= '0;
        end else begin
            if (load) begin
                p_data   <= data;
                p_dp     <= dp;
                p_blank  <= blank;
                p_blink  <= blink;
                p_bright <= bright;
            end
            if (frame_end) begin
                a_data   <= load ? data   : p_data;
                a_dp     <= load ? dp     : p_dp;
                a_blank  <= load ? blank  : p_blank;
                a_blink  <= load ? blink  : p_blink;
                a_bright <= load ? bright : p_bright;
            end
        end
    end

    // slot_end darkens the last cycle of every slot so the anode switch never ghosts
    always_comb begin
        nib     = a_data[{idx, 2'b00} +: 4];
        dark    = a_blank[idx] || (a_blink[idx] && blink_ph) || (phase > a_bright) || slot_end;
        an_int  = '0;
        seg_int = SEG_OFF;
        if (!dark) begin
            an_int  = DIGITS'(1) << idx;
            seg_int = {a_dp[idx], seg_decode(nib)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= {DIGITS{POL}};
            seg <= SEG_OFF ^ {8{POL}};
        end else begin
            an  <= an_int ^ {DIGITS{POL}};
            seg <= seg_int ^ {8{POL}};
        end
    end

    assign frame_done = frame_end;

endmodule

// File: tb/tb_io_seg_scan.sv
// Bench for io_seg_scan (DIGITS=4, SUB=2, BLINK_FRAMES=2, active-low pins): a cycle-position model
// predicts pin levels each clock into a scoreboard queue, popped and compared after the edge.
module tb_io_seg_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  blink = '0;
    logic [3:0]  bright = '0;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    always #5 clk = ~clk;

    io_seg_scan #(
        .DIGITS       (4),
        .SUB          (2),
        .BLINK_FRAMES (2),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data       (data),
        .dp         (dp),
        .blank      (blank),
        .blink      (blink),
        .bright     (bright),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  blink;
        logic [3:0]  bright;
    } disp_t;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } pins_t;

    localparam disp_t DISP_RST = '{data: 16'h0, dp: 4'h0, blank: 4'hF, blink: 4'h0, bright: 4'h0};

    pins_t sb[$];
    disp_t pend, act;
    int    tc, fc;
    int    total = 0;
    int    bad = 0;
    bit    started = 1'b0;

    always @(negedge clk) begin
        if (started) begin
            assert ($onehot0(~an));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, tc, got, exp);
        end
    endtask

    // One clock: check frame_done for the current counter cycle, predict the pins the
    // coming edge registers, advance the model, then compare after the edge.
    task automatic tick();
        int    pos, i, ph;
        logic  bph, dark;
        pins_t e;
        disp_t cur;
        pos = tc % 128;
        i   = pos / 32;
        ph  = (pos % 32) / 2;
        bph = fc[1];
        check("frame_done", 32'(frame_done), 32'(pos == 127));
        dark = act.blank[i] || (act.blink[i] && bph) || (ph > int'(act.bright)) || ((pos % 32) == 31);
        if (rst || dark) begin
            e = '{an: 4'hF, seg: 8'hFF};
        end else begin
            e.an  = ~(4'b0001 << i);
            e.seg = ~{act.dp[i], HEX[act.data[i*4 +: 4]]};
        end
        sb.push_back(e);
        cur = '{data: data, dp: dp, blank: blank, blink: blink, bright: bright};
        if (rst) begin
            tc = 0;
            fc = 0;
            pend = DISP_RST;
            act = DISP_RST;
        end else begin
            if (pos == 127) begin
                act = load ? cur : pend;
                fc++;
            end
            if (load) pend = cur;
            tc++;
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("an", 32'(an), 32'(e.an));
        check("seg", 32'(seg), 32'(e.seg));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic goto_pos(input int p);
        while ((tc % 128) != p) tick();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] bl,
                           input logic [3:0] bk, input logic [3:0] br);
        data   = d;
        dp     = p;
        blank  = bl;
        blink  = bk;
        bright = br;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    initial begin
        pend = DISP_RST;
        act  = DISP_RST;
        tc   = 0;
        fc   = 0;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        started = 1'b1;
        run(2);
        rst = 1'b0;

        // dark after reset, frame_done every 128 clocks
        run(300);

        // mid-frame load of 0..3 at full brightness
        goto_pos(50);
        do_load(16'h3210, 4'h0, 4'h0, 4'h0, 4'hF);
        run(300);

        // quarter brightness
        do_load(16'h3210, 4'h0, 4'h0, 4'h0, 4'h3);
        run(300);

        // blink digit 1, dp on digit 0
        do_load(16'h3210, 4'b0001, 4'h0, 4'b0010, 4'hF);
        run(128 * 6);

        // two loads in one frame: last one wins
        goto_pos(10);
        do_load(16'h1111, 4'h0, 4'h0, 4'h0, 4'hF);
        goto_pos(70);
        do_load(16'hABCD, 4'h0, 4'h0, 4'h0, 4'hF);
        run(200);

        // load on the frame-end cycle bypasses into the next frame
        goto_pos(127);
        do_load(16'hE7F6, 4'b1010, 4'b0100, 4'h0, 4'hF);
        run(200);

        // reset mid-slot
        goto_pos(40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
